// File: rtl/cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : cu_pkg                                                   |
// | Purpose   : Shared types and encodings for the multi-cycle RV32I     |
// |             control unit: FSM state enum, opcodes, and the select /  |
// |             control encodings driven onto the datapath.              |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   // Opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALUControl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ImmSrc
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : alu_decoder                                              |
// | Purpose   : Combinational funct3/funct7 decode to ALUControl for     |
// |             R-type and I-type ALU instructions.                      |
// | Ports     : funct3, funct7_5, is_rtype  -> alu_control, illegal      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module alu_decoder
   import cu_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output logic [2:0] alu_control,
   output logic       illegal
);

   // funct7[5] is only meaningful for R-type; for I-type it is an
   // immediate bit and must not affect the decode.
   logic w_alt;
   assign w_alt = is_rtype & funct7_5;

   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (funct3)
         3'b000: alu_control = w_alt ? ALU_SUB : ALU_ADD;
         3'b111: begin alu_control = ALU_AND; illegal = w_alt; end
         3'b110: begin alu_control = ALU_OR;  illegal = w_alt; end
         3'b010: begin alu_control = ALU_SLT; illegal = w_alt; end
         default: illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : multicycle_cu                                            |
// | Purpose   : Multi-cycle RV32I control unit. Moore FSM sequencing     |
// |             fetch/decode/execute/memory/writeback over a shared      |
// |             memory port, with a retired-instruction counter and a    |
// |             sticky illegal-instruction flag.                         |
// | Ports     : clk, rst, instr, Zero, mem_ready  (inputs)               |
// |             mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,   |
// |             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,         |
// |             illegal, instret                     (outputs)           |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module multicycle_cu
   import cu_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int CNT_W         = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instret;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_ready;
   logic       w_is_lui;
   logic       w_is_beq;
   logic [2:0] w_alu_ctrl;
   logic       w_alu_illegal;
   logic       w_funct7_bad;
   logic       w_retire;
   logic       w_unused;

   assign w_opcode = instr[6:0];
   assign w_funct3 = instr[14:12];
   assign w_funct7 = instr[31:25];
   assign w_unused = ^{instr[24:15], instr[11:7]};

   assign w_ready      = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign w_is_lui     = (w_opcode == OP_LUI);
   assign w_is_beq     = (w_funct3 == 3'b000);
   // Only funct7 = 0x00 or 0x20 are valid for R-type
   assign w_funct7_bad = w_funct7[6] | (|w_funct7[4:0]);

   alu_decoder u_alu_decoder (
      .funct3      (w_funct3),
      .funct7_5    (w_funct7[5]),
      .is_rtype    (w_opcode == OP_R),
      .alu_control (w_alu_ctrl),
      .illegal     (w_alu_illegal)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (w_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OP_LOAD, OP_STORE:
                  w_next = (w_funct3 == 3'b010) ? S_MEMADR : S_ILLEGAL;
               OP_R:
                  w_next = (w_alu_illegal | w_funct7_bad) ? S_ILLEGAL : S_EXECR;
               OP_I:
                  w_next = w_alu_illegal ? S_ILLEGAL : S_EXECI;
               OP_LUI:
                  w_next = S_EXECI;
               OP_BRANCH:
                  w_next = (w_funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
               OP_JAL:
                  w_next = S_JAL;
               default:
                  w_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   w_next = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
         S_MEMWB:    w_next = S_FETCH;
         S_MEMWRITE: if (w_ready) w_next = S_FETCH;
         S_EXECR,
         S_EXECI:    w_next = S_ALUWB;
         S_ALUWB:    w_next = S_FETCH;
         S_BRANCH:   w_next = S_FETCH;
         S_JAL:      w_next = S_ALUWB;
         S_ILLEGAL:  w_next = S_ILLEGAL;
         default:    w_next = S_FETCH;
      endcase
   end

   // Output decode
   always_comb begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
            IRWrite   = w_ready;
            PCWrite   = w_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_MEM;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = w_alu_ctrl;
         end
         S_EXECI: begin
            // lui reuses the I path as 0 + U-immediate
            ALUSrcA    = w_is_lui ? SRCA_ZERO : SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = w_is_lui ? ALU_ADD : w_alu_ctrl;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUControl = ALU_SUB;
            PCWrite    = w_is_beq ? Zero : ~Zero;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         S_ILLEGAL:  illegal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      case (w_opcode)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         OP_LUI:    ImmSrc = IMM_U;
         default:   ImmSrc = IMM_I;
      endcase
   end

   // Retirement is the transition back into FETCH from a final state
   assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                     (r_state == S_BRANCH) ||
                     ((r_state == S_MEMWRITE) && w_ready);

   always_ff @(posedge clk) begin
      if (rst)           r_instret <= '0;
      else if (w_retire) r_instret <= r_instret + CNT_W'(1);
   end

   assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_multicycle_cu                                         |
// | Purpose   : Directed self-checking bench for multicycle_cu.          |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_multicycle_cu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        Zero;
   logic        mem_ready;

   logic        mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, illegal;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0]  ImmSrc, ALUControl;
   logic [31:0] instret;

   logic        w4_mem_req, w4_MemWrite, w4_IRWrite, w4_PCWrite, w4_AdrSrc;
   logic        w4_RegWrite, w4_illegal;
   logic [1:0]  w4_ResultSrc, w4_ALUSrcA, w4_ALUSrcB;
   logic [2:0]  w4_ImmSrc, w4_ALUControl;
   logic [3:0]  w4_instret;

   // {mem_req,MemWrite,IRWrite,PCWrite,AdrSrc,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,illegal}
   logic [15:0] ctl;
   assign ctl = {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal};

   localparam logic [15:0] C_FETCH    = 16'hB220;
   localparam logic [15:0] C_FETCHW   = 16'h8220;
   localparam logic [15:0] C_DECODE   = 16'h0050;
   localparam logic [15:0] C_EXECI    = 16'h0090;
   localparam logic [15:0] C_MEMADR   = 16'h0090;
   localparam logic [15:0] C_EXECLUI  = 16'h00D0;
   localparam logic [15:0] C_EXECSUB  = 16'h0082;
   localparam logic [15:0] C_ALUWB    = 16'h0400;
   localparam logic [15:0] C_BRTAKEN  = 16'h1082;
   localparam logic [15:0] C_BRNOT    = 16'h0082;
   localparam logic [15:0] C_MEMREAD  = 16'h8800;
   localparam logic [15:0] C_MEMWB    = 16'h0500;
   localparam logic [15:0] C_MEMWRITE = 16'hC800;
   localparam logic [15:0] C_JAL      = 16'h1060;
   localparam logic [15:0] C_ILLEGAL  = 16'h0001;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_BNE  = 32'h00209463;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   int n_checks = 0;
   int n_fails  = 0;

   multicycle_cu dut (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .illegal(illegal), .instret(instret)
   );

   multicycle_cu #(.CNT_W(4)) dut_w4 (
      .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(w4_mem_req), .MemWrite(w4_MemWrite), .IRWrite(w4_IRWrite),
      .PCWrite(w4_PCWrite), .AdrSrc(w4_AdrSrc), .RegWrite(w4_RegWrite),
      .ResultSrc(w4_ResultSrc), .ALUSrcA(w4_ALUSrcA), .ALUSrcB(w4_ALUSrcB),
      .ImmSrc(w4_ImmSrc), .ALUControl(w4_ALUControl), .illegal(w4_illegal),
      .instret(w4_instret)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check control word for the current state, then advance one clock.
   task automatic step(input string tag, input logic [15:0] e);
      #1;
      check_val(tag, 32'(ctl), 32'(e));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; instr = I_ADDI; Zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_val("reset_ctl", 32'(ctl), 32'(C_FETCH));
      check_val("reset_instret", instret, 32'd0);
      rst = 1'b0;

      // addi x1,x0,5
      step("addi_fetch", C_FETCH);
      step("addi_decode", C_DECODE);
      #1 check_val("addi_immsrc", 32'(ImmSrc), 32'd0);
      step("addi_execi", C_EXECI);
      check_val("addi_instret_pre", instret, 32'd0);
      step("addi_aluwb", C_ALUWB);
      check_val("addi_instret", instret, 32'd1);

      // bne, Zero=0 (taken)
      instr = I_BNE; Zero = 1'b0;
      step("bne0_fetch", C_FETCH);
      step("bne0_decode", C_DECODE);
      #1 check_val("bne_immsrc", 32'(ImmSrc), 32'd2);
      step("bne0_branch", C_BRTAKEN);
      check_val("bne0_instret", instret, 32'd2);

      // bne, Zero=1 (not taken)
      Zero = 1'b1;
      step("bne1_fetch", C_FETCH);
      step("bne1_decode", C_DECODE);
      step("bne1_branch", C_BRNOT);
      check_val("bne1_instret", instret, 32'd3);
      Zero = 1'b0;

      // lw with 3 wait cycles in MEMREAD
      instr = I_LW;
      step("lw_fetch", C_FETCH);
      step("lw_decode", C_DECODE);
      step("lw_memadr", C_MEMADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("lw_memread_wait", C_MEMREAD);
      mem_ready = 1'b1;
      step("lw_memread", C_MEMREAD);
      check_val("lw_instret_pre", instret, 32'd3);
      step("lw_memwb", C_MEMWB);
      check_val("lw_instret", instret, 32'd4);

      // sw, zero wait
      instr = I_SW;
      step("sw_fetch", C_FETCH);
      step("sw_decode", C_DECODE);
      #1 check_val("sw_immsrc", 32'(ImmSrc), 32'd1);
      step("sw_memadr", C_MEMADR);
      step("sw_memwrite", C_MEMWRITE);
      check_val("sw_instret", instret, 32'd5);

      // jal
      instr = I_JAL;
      step("jal_fetch", C_FETCH);
      step("jal_decode", C_DECODE);
      step("jal_jal", C_JAL);
      step("jal_aluwb", C_ALUWB);
      check_val("jal_instret", instret, 32'd6);

      // lui
      instr = I_LUI;
      step("lui_fetch", C_FETCH);
      step("lui_decode", C_DECODE);
      #1 check_val("lui_immsrc", 32'(ImmSrc), 32'd4);
      step("lui_execi", C_EXECLUI);
      step("lui_aluwb", C_ALUWB);
      check_val("lui_instret", instret, 32'd7);

      // sub with one fetch wait
      instr = I_SUB; mem_ready = 1'b0;
      step("sub_fetch_wait", C_FETCHW);
      mem_ready = 1'b1;
      step("sub_fetch", C_FETCH);
      step("sub_decode", C_DECODE);
      step("sub_execr", C_EXECSUB);
      step("sub_aluwb", C_ALUWB);
      check_val("sub_instret", instret, 32'd8);

      // illegal opcode holds until reset
      instr = I_BAD;
      step("bad_fetch", C_FETCH);
      step("bad_decode", C_DECODE);
      for (int i = 0; i < 10; i++) step("bad_illegal", C_ILLEGAL);
      check_val("bad_instret", instret, 32'd8);
      rst = 1'b1; instr = I_ADDI;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check_val("bad_rst_illegal", 32'(illegal), 32'd0);
      check_val("bad_rst_instret", instret, 32'd0);
      step("bad_rst_fetch", C_FETCH);
      step("addi2_decode", C_DECODE);
      step("addi2_execi", C_EXECI);
      step("addi2_aluwb", C_ALUWB);
      check_val("addi2_instret", instret, 32'd1);

      // reset during a MEMWRITE wait, with mem_ready rising on the same edge
      instr = I_SW;
      step("swr_fetch", C_FETCH);
      step("swr_decode", C_DECODE);
      step("swr_memadr", C_MEMADR);
      mem_ready = 1'b0;
      step("swr_memwrite_wait", C_MEMWRITE);
      step("swr_memwrite_wait", C_MEMWRITE);
      rst = 1'b1; mem_ready = 1'b1;
      @(posedge clk); #1;
      check_val("swr_rst_ctl", 32'(ctl), 32'(C_FETCH));
      check_val("swr_rst_memwrite", 32'(MemWrite), 32'd0);
      check_val("swr_rst_instret", instret, 32'd0);
      rst = 1'b0;

      // 17 addi: 4-bit counter wraps to 1
      instr = I_ADDI;
      for (int i = 0; i < 17; i++) repeat (4) @(posedge clk);
      #2;
      check_val("wrap_w4_instret", 32'(w4_instret), 32'd1);
      check_val("wrap_instret", instret, 32'd17);
      check_val("wrap_ctl", 32'(ctl), 32'(C_FETCH));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
